// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter: queued request format and arbiter states.
// Pure declarations; no logic, no latency, no flow control.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of write-back requests; push visible next cycle, head read combinationally.
// Pushes are ignored when full and pops when empty; per-entry rd/valid exported for hazard decode.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  wb_req_t          i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output wb_req_t          o_head_dat,
  output logic [DEPTH-1:0] o_ent_vld,
  output logic [4:0]       o_ent_rd [DEPTH]
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_count;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  always_comb begin
    o_ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_rd[i]  = r_mem[i].rd;
      o_ent_vld[i] = ({1'b0, AW'(AW'(i) - r_rd_ptr[AW-1:0])} < w_count);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline result (A) or queued long-latency result (B), one registered write per cycle.
// A written the cycle after acceptance, B no earlier than two cycles after handshake; b_ready = !full, A held only via a_stall.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pending
);

  localparam int             WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(MAX_WAIT - 1);

  wb_state_t        r_state;
  wb_state_t        w_state_nxt;
  logic [WW-1:0]    r_wait_cnt;
  logic             r_reg_wr;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  logic             w_full;
  logic             w_empty;
  wb_req_t          w_head;
  logic [DEPTH-1:0] w_ent_vld;
  logic [4:0]       w_ent_rd [DEPTH];
  logic             w_stall;
  logic             w_a_ok;
  logic             w_pop;
  logic             w_push;

  assign w_stall = (r_state == ST_STALL);
  assign w_a_ok  = a_valid && (a_rd != REG_ZERO);
  assign w_pop   = !w_empty && (w_stall || !w_a_ok);
  // Zero-destination B results complete the handshake but never occupy a slot.
  assign w_push  = b_valid && !w_full && (b_rd != REG_ZERO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_push_dat ('{rd: b_rd, data: b_data}),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head),
    .o_ent_vld  (w_ent_vld),
    .o_ent_rd   (w_ent_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (!w_empty && !w_pop && (r_wait_cnt == WAIT_LAST)) w_state_nxt = ST_STALL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_reg_wr   <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_empty || w_pop)            r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_LAST) r_wait_cnt <= r_wait_cnt + 1'b1;

      r_reg_wr <= w_pop || w_a_ok;
      if (w_pop) begin
        r_waddr <= w_head.rd;
        r_wdata <= w_head.data;
      end else if (w_a_ok) begin
        r_waddr <= a_rd;
        r_wdata <= a_data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i]) pending[w_ent_rd[i]] = 1'b1;
    end
  end

  assign a_stall = w_stall;
  assign b_ready = !w_full;
  assign reg_wr  = r_reg_wr;
  assign waddr   = r_waddr;
  assign wdata   = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int TB_DEPTH    = 4;
  localparam int TB_MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(.DEPTH(TB_DEPTH), .MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: queued B results, age of the waiting head, and expected outputs.
  wb_req_t     m_q[$];
  int          m_wait;
  bit          m_stall;
  logic        m_reg_wr;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_q.delete();
    m_wait   = 0;
    m_stall  = 0;
    m_reg_wr = 0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    foreach (m_q[i]) p[m_q[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic model_edge();
    int sz;
    bit a_ok, pop, push, nstall;
    sz     = m_q.size();
    a_ok   = a_valid && (a_rd != 0);
    pop    = (sz > 0) && (m_stall || !a_ok);
    push   = b_valid && (sz < TB_DEPTH) && (b_rd != 0);
    nstall = (sz > 0) && !pop && (m_wait == TB_MAX_WAIT - 1);
    if (pop) begin
      m_reg_wr = 1;
      m_waddr  = m_q[0].rd;
      m_wdata  = m_q[0].data;
      void'(m_q.pop_front());
    end else if (a_ok && !m_stall) begin
      m_reg_wr = 1;
      m_waddr  = a_rd;
      m_wdata  = a_data;
    end else begin
      m_reg_wr = 0;
    end
    if (push) m_q.push_back(wb_req_t'{rd: b_rd, data: b_data});
    if (sz == 0 || pop)                m_wait = 0;
    else if (m_wait < TB_MAX_WAIT - 1) m_wait = m_wait + 1;
    m_stall = nstall;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    model_reset();
    #2;
    checks++; if (reg_wr !== 1'b0)   begin failures++; $display("FAIL reset_reg_wr got=%0b exp=0", reg_wr); end
    checks++; if (waddr !== 5'd0)    begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    checks++; if (wdata !== 32'd0)   begin failures++; $display("FAIL reset_wdata got=%0h exp=0", wdata); end
    checks++; if (a_stall !== 1'b0)  begin failures++; $display("FAIL reset_a_stall got=%0b exp=0", a_stall); end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL reset_pending got=%0h exp=0", pending); end
    checks++; if (b_ready !== 1'b1)  begin failures++; $display("FAIL reset_b_ready got=%0b exp=1", b_ready); end
    #10 reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_a_write();
    a_valid = 1; a_rd = 5; a_data = 32'h11;
    step();
    idle_inputs();
    checks++; if (reg_wr !== 1'b1)     begin failures++; $display("FAIL a_reg_wr got=%0b exp=1", reg_wr); end
    checks++; if (waddr !== 5'd5)      begin failures++; $display("FAIL a_waddr got=%0d exp=5", waddr); end
    checks++; if (wdata !== 32'h11)    begin failures++; $display("FAIL a_wdata got=%0h exp=11", wdata); end
    step();
    checks++; if (reg_wr !== 1'b0)     begin failures++; $display("FAIL a_reg_wr_drop got=%0b exp=0", reg_wr); end
    checks++; if (waddr !== 5'd5)      begin failures++; $display("FAIL a_waddr_hold got=%0d exp=5", waddr); end
  endtask

  task automatic test_b_single();
    b_valid = 1; b_rd = 7; b_data = 32'hAB;
    step();
    idle_inputs();
    checks++; if (pending !== 32'h80)  begin failures++; $display("FAIL b_pending_set got=%0h exp=80", pending); end
    checks++; if (reg_wr !== 1'b0)     begin failures++; $display("FAIL b_no_early_wr got=%0b exp=0", reg_wr); end
    step();
    checks++; if (reg_wr !== 1'b1)     begin failures++; $display("FAIL b_reg_wr got=%0b exp=1", reg_wr); end
    checks++; if (waddr !== 5'd7)      begin failures++; $display("FAIL b_waddr got=%0d exp=7", waddr); end
    checks++; if (wdata !== 32'hAB)    begin failures++; $display("FAIL b_wdata got=%0h exp=ab", wdata); end
    checks++; if (pending !== 32'd0)   begin failures++; $display("FAIL b_pending_clr got=%0h exp=0", pending); end
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < TB_DEPTH; i++) begin
      a_valid = 1; a_rd = 5'(i + 1); a_data = 32'h100 + i;
      b_valid = 1; b_rd = 5'(10 + i); b_data = 32'hB0 + i;
      step();
      checks++; if (reg_wr !== 1'b1 || waddr !== 5'(i + 1))
        begin failures++; $display("FAIL fill_a_write%0d got=%0b/%0d exp=1/%0d", i, reg_wr, waddr, i + 1); end
    end
    idle_inputs();
    checks++; if (b_ready !== 1'b0)     begin failures++; $display("FAIL fill_b_ready got=%0b exp=0", b_ready); end
    checks++; if (pending !== 32'h3C00) begin failures++; $display("FAIL fill_pending got=%0h exp=3c00", pending); end
    for (int i = 0; i < TB_DEPTH; i++) begin
      step();
      checks++; if (reg_wr !== 1'b1 || waddr !== 5'(10 + i) || wdata !== 32'hB0 + i)
        begin failures++; $display("FAIL drain%0d got=%0b/%0d/%0h exp=1/%0d/%0h", i, reg_wr, waddr, wdata, 10 + i, 32'hB0 + i); end
    end
    step();
    checks++; if (reg_wr !== 1'b0 || b_ready !== 1'b1)
      begin failures++; $display("FAIL drain_done got=%0b/%0b exp=0/1", reg_wr, b_ready); end
  endtask

  task automatic test_zero_rd();
    a_valid = 1; a_rd = 0; a_data = 32'hDEAD;
    b_valid = 1; b_rd = 0; b_data = 32'hBEEF;
    step();
    idle_inputs();
    checks++; if (reg_wr !== 1'b0)   begin failures++; $display("FAIL zero_reg_wr got=%0b exp=0", reg_wr); end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL zero_pending got=%0h exp=0", pending); end
    checks++; if (b_ready !== 1'b1)  begin failures++; $display("FAIL zero_b_ready got=%0b exp=1", b_ready); end
    a_valid = 1; a_rd = 4; a_data = 32'h44;
    b_valid = 1; b_rd = 12; b_data = 32'hC12;
    step();
    a_rd = 0; a_data = 32'h99; b_valid = 0;
    step();
    idle_inputs();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd12 || wdata !== 32'hC12)
      begin failures++; $display("FAIL zero_a_slot_to_b got=%0b/%0d/%0h exp=1/12/c12", reg_wr, waddr, wdata); end
    step();
  endtask

  task automatic test_forced_stall();
    int n;
    a_valid = 1; a_rd = 3; a_data = 32'h300;
    b_valid = 1; b_rd = 21; b_data = 32'h2121;
    step();
    b_valid = 0; b_rd = 0;
    n = 0;
    while (a_stall !== 1'b1 && n < 20) begin
      a_rd = 5'(1 + (n % 4)); a_data = 32'h500 + n;
      step();
      n++;
    end
    checks++; if (n != TB_MAX_WAIT) begin failures++; $display("FAIL stall_delay got=%0d exp=%0d", n, TB_MAX_WAIT); end
    a_rd = 20; a_data = 32'h2020;
    step();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd21 || wdata !== 32'h2121)
      begin failures++; $display("FAIL stall_pops_b got=%0b/%0d/%0h exp=1/21/2121", reg_wr, waddr, wdata); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL stall_one_cycle got=%0b exp=0", a_stall); end
    step();
    idle_inputs();
    checks++; if (reg_wr !== 1'b1 || waddr !== 5'd20 || wdata !== 32'h2020)
      begin failures++; $display("FAIL stall_held_a got=%0b/%0d/%0h exp=1/20/2020", reg_wr, waddr, wdata); end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!m_stall) begin
        a_valid = ($urandom_range(0, 9) < 8);
        a_rd    = 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      b_valid = ($urandom_range(0, 2) == 0);
      b_rd    = 5'($urandom_range(0, 31));
      b_data  = $urandom;
      step();
      checks++; if (reg_wr !== m_reg_wr) begin failures++; $display("FAIL rnd_reg_wr c=%0d got=%0b exp=%0b", c, reg_wr, m_reg_wr); end
      checks++; if (m_reg_wr && (waddr !== m_waddr || wdata !== m_wdata))
        begin failures++; $display("FAIL rnd_write c=%0d got=%0d/%0h exp=%0d/%0h", c, waddr, wdata, m_waddr, m_wdata); end
      checks++; if (a_stall !== m_stall) begin failures++; $display("FAIL rnd_a_stall c=%0d got=%0b exp=%0b", c, a_stall, m_stall); end
      checks++; if (pending !== m_pending()) begin failures++; $display("FAIL rnd_pending c=%0d got=%0h exp=%0h", c, pending, m_pending()); end
      checks++; if (b_ready !== (m_q.size() < TB_DEPTH))
        begin failures++; $display("FAIL rnd_b_ready c=%0d got=%0b exp=%0b", c, b_ready, m_q.size() < TB_DEPTH); end
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_async_reset();
    int writes;
    a_valid = 1; a_rd = 1; a_data = 32'h1;
    b_valid = 1; b_rd = 9; b_data = 32'h9;
    step();
    b_rd = 10; b_data = 32'hA;
    step();
    b_valid = 0; a_rd = 2; a_data = 32'h2;
    step();
    checks++; if (pending !== 32'h600 || reg_wr !== 1'b1)
      begin failures++; $display("FAIL areset_pre got=%0h/%0b exp=600/1", pending, reg_wr); end
    #2 reset = 0;
    #1;
    checks++; if (reg_wr !== 1'b0)   begin failures++; $display("FAIL areset_reg_wr got=%0b exp=0", reg_wr); end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL areset_pending got=%0h exp=0", pending); end
    checks++; if (b_ready !== 1'b1)  begin failures++; $display("FAIL areset_b_ready got=%0b exp=1", b_ready); end
    idle_inputs();
    @(negedge clk);
    reset = 1;
    model_reset();
    writes = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (reg_wr === 1'b1) writes++;
    end
    checks++; if (writes != 0) begin failures++; $display("FAIL areset_no_writes got=%0d exp=0", writes); end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_b_single();
    test_fill_drain();
    test_zero_rd();
    test_forced_stall();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
